// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if
//   Request/response bundle between the control unit (master) and the
//   multiply/divide unit (slave).
//   start/op/a/b      : operation request, sampled when the unit accepts it
//   hi_we/lo_we/wdata : MTHI/MTLO write port
//   busy/done         : in-flight flag and one-cycle completion pulse
//   div_by_zero       : sticky flag for the last accepted operation
//   hi/lo             : HI/LO register contents
interface mult_div_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO pair. One operand bit
//   is processed per cycle; signed ops run on magnitudes and are fixed up in
//   a final correction cycle. Also services MTHI/MTLO writes while idle.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : mult_div_unit_if.slave (request, MTHI/MTLO, status, HI/LO)
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              reset,
  mult_div_unit_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t             r_state;
  logic [1:0]         r_op;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;    // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   r_opd;    // multiplicand or divisor magnitude
  logic               r_neg_q;  // negate product / quotient
  logic               r_neg_r;  // negate remainder
  logic               r_dz;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  // Operand magnitudes at accept; unsigned ops pass through untouched.
  logic             w_a_neg, w_b_neg, w_b_zero, w_is_div;
  logic [WIDTH-1:0] w_a_abs, w_b_abs;

  assign w_a_neg  = bus.op[0] & bus.a[WIDTH-1];
  assign w_b_neg  = bus.op[0] & bus.b[WIDTH-1];
  assign w_a_abs  = w_a_neg ? -bus.a : bus.a;
  assign w_b_abs  = w_b_neg ? -bus.b : bus.b;
  assign w_b_zero = (bus.b == '0);
  assign w_is_div = bus.op[1];

  // Shift-add step: add multiplicand into upper half when the current
  // multiplier LSB is set, then shift the whole accumulator right.
  logic [WIDTH:0] w_mul_sum;
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                   + {1'b0, (r_acc[0] ? r_opd : {WIDTH{1'b0}})};

  // Restoring step: the shifted remainder needs one extra bit because it can
  // reach up to 2*divisor-1 before the trial subtract.
  logic [WIDTH:0]   w_rem_sh, w_rem_sub;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nxt;
  assign w_rem_sh  = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_ge      = (w_rem_sh >= {1'b0, r_opd});
  assign w_rem_sub = w_rem_sh - {1'b0, r_opd};
  assign w_rem_nxt = w_ge ? w_rem_sub[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];

  // Sign correction applied in FIX.
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem;
  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_opd   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            // start has priority; any concurrent MTHI/MTLO is dropped
            r_op    <= bus.op;
            r_cnt   <= CW'(WIDTH-1);
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_dz    <= w_is_div & w_b_zero;
            if (w_is_div && w_b_zero) begin
              // Divide by zero bypasses RUN; FIX copies these straight out.
              r_acc   <= {bus.a, {WIDTH{1'b1}}};
              r_state <= S_FIX;
            end else if (w_is_div) begin
              r_acc   <= {{WIDTH{1'b0}}, w_a_abs};
              r_opd   <= w_b_abs;
              r_state <= S_RUN;
            end else begin
              r_acc   <= {{WIDTH{1'b0}}, w_b_abs};
              r_opd   <= w_a_abs;
              r_state <= S_RUN;
            end
          end else begin
            if (bus.hi_we) r_hi <= bus.wdata;
            if (bus.lo_we) r_lo <= bus.wdata;
          end
        end

        S_RUN: begin
          if (r_op[1]) r_acc <= {w_rem_nxt, r_acc[WIDTH-2:0], w_ge};
          else         r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
          if (r_cnt == '0) r_state <= S_FIX;
          else             r_cnt   <= r_cnt - CW'(1);
        end

        S_FIX: begin
          if (r_dz) begin
            r_hi <= r_acc[2*WIDTH-1:WIDTH];
            r_lo <= r_acc[WIDTH-1:0];
          end else if (r_op[1]) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dz;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
//   Directed vectors with hand-computed HI/LO results, latency checks and
//   control corner cases for mult_div_unit (WIDTH = 32).
module tb_mult_div_unit;

  localparam int W   = 32;
  localparam int LIM = 60;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  mult_div_unit_if #(.WIDTH(W)) bus();

  mult_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive a request for exactly one accept edge; leaves time at edge+1.
  task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
  endtask

  // lat = cycle index (1 = first cycle after accept) at which done is seen.
  task automatic wait_done(output int lat, output int bc);
    lat = 1;
    bc  = 0;
    while (bus.done !== 1'b1 && lat < LIM) begin
      if (bus.busy === 1'b1) bc++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic [1:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ehi, input logic [W-1:0] elo,
                       input logic edz, input int elat, input int ebc);
    int lat, bc;
    start_op(op, a, b);
    wait_done(lat, bc);
    chk({tag, ".done"}, bus.done, 1);
    chk({tag, ".lat"}, lat, elat);
    if (ebc >= 0) chk({tag, ".busycyc"}, bc, ebc);
    chk({tag, ".hi"}, bus.hi, ehi);
    chk({tag, ".lo"}, bus.lo, elo);
    chk({tag, ".dz"}, bus.div_by_zero, edz);
    chk({tag, ".busy0"}, bus.busy, 0);
    @(posedge clk); #1;
    chk({tag, ".pulse"}, bus.done, 0);
  endtask

  initial begin
    int lat, bc, seen;
    n_chk = 0; n_fail = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;

    #12;
    chk("rst.hi",   bus.hi, 0);
    chk("rst.lo",   bus.lo, 0);
    chk("rst.busy", bus.busy, 0);
    chk("rst.done", bus.done, 0);
    chk("rst.dz",   bus.div_by_zero, 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    do_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34, 33);
    do_op("mult_neg",  2'b01, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 34, -1);
    do_op("mult_min",  2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 34, -1);
    do_op("div_neg",   2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34, -1);
    do_op("divu",      2'b10, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, 34, -1);
    do_op("div_zero",  2'b11, 32'h0000_1234, 32'h0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 2, 1);
    // start beats a same-cycle MTHI; flag clears on this accept
    bus.hi_we = 1'b1; bus.wdata = 32'h5555;
    do_op("multu_clr", 2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 34, -1);
    do_op("div_ovf",   2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 34, -1);

    // start and MTHI during a MULT are both ignored
    start_op(2'b01, 32'd6, 32'd7);
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'd100; bus.b = 32'd7;
    bus.hi_we = 1'b1; bus.wdata = 32'hDEAD;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.hi_we = 1'b0;
    wait_done(lat, bc);
    chk("busy_ign.done", bus.done, 1);
    chk("busy_ign.hi", bus.hi, 0);
    chk("busy_ign.lo", bus.lo, 42);
    @(posedge clk); #1;
    chk("busy_ign.noqueue", bus.busy, 0);
    chk("busy_ign.hi2", bus.hi, 0);

    // reset in the middle of RUN
    start_op(2'b00, 32'hFFFF_FFFF, 32'd3);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_run.hi",   bus.hi, 0);
    chk("rst_run.lo",   bus.lo, 0);
    chk("rst_run.busy", bus.busy, 0);
    chk("rst_run.dz",   bus.div_by_zero, 0);
    @(negedge clk); reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) seen++;
    end
    chk("rst_run.nodone", seen, 0);

    bus.lo_we = 1'b1; bus.wdata = 32'hBEEF;
    @(posedge clk); #1;
    bus.lo_we = 1'b0;
    chk("mtlo.lo", bus.lo, 32'hBEEF);
    chk("mtlo.hi", bus.hi, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
